ks_memory: RTL

KS_MEMORY -- requirements
Module: ks_memory

---
 rtl/ks_memory_if.sv | 35 +++
 rtl/ks_memory.sv | 84 ++++++++
 2 files changed

// File: rtl/ks_memory_if.sv
// Core + loader bus for ks_memory; write_violation is present only under KS_MEM_PROTECT_EN.
interface ks_memory_if;
  logic [4:0]  ram_addr;
  logic        write_enable;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        load_last;
  logic        reload;
  logic        core_hold;
`ifdef KS_MEM_PROTECT_EN
  logic        write_violation;
`endif

  modport master (
    output ram_addr, write_enable, data_out,
    output load_valid, load_addr, load_data, load_last, reload,
    input  data_in, load_ready, core_hold
`ifdef KS_MEM_PROTECT_EN
    , input write_violation
`endif
  );

  modport slave (
    input  ram_addr, write_enable, data_out,
    input  load_valid, load_addr, load_data, load_last, reload,
    output data_in, load_ready, core_hold
`ifdef KS_MEM_PROTECT_EN
    , output write_violation
`endif
  );
endinterface

// File: rtl/ks_memory.sv
// 32x16 core memory with a LOAD/RUN loader FSM; 1-cycle registered read, read-before-write.
// KS_MEM_PROTECT_EN: drops core writes to words 0-15 in RUN and raises sticky write_violation.
module ks_memory (
  input logic         clk,
  input logic         rst_n,
  ks_memory_if.slave  mem_bus
);
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_mem [32];
  logic [15:0] r_data_in;

  logic w_loading;
  logic w_load_acc;
  logic w_core_wr;
  logic w_wr_allowed;

  assign w_loading  = (r_state == ST_LOAD);
  assign w_load_acc = w_loading & mem_bus.load_valid;

`ifdef KS_MEM_PROTECT_EN
  logic w_violation;
  logic r_write_violation;

  // Lower half of the address space holds the program image.
  assign w_wr_allowed = mem_bus.ram_addr[4];
  assign w_violation  = ~w_loading & mem_bus.write_enable & ~mem_bus.ram_addr[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_violation <= 1'b0;
    end else if (!w_loading && mem_bus.reload) begin
      r_write_violation <= 1'b0;
    end else if (w_violation) begin
      r_write_violation <= 1'b1;
    end
  end

  assign mem_bus.write_violation = r_write_violation;
`else
  assign w_wr_allowed = 1'b1;
`endif

  assign w_core_wr = ~w_loading & mem_bus.write_enable & w_wr_allowed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (mem_bus.load_valid && mem_bus.load_last) r_state <= ST_RUN;
        ST_RUN:  if (mem_bus.reload) r_state <= ST_LOAD;
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= 16'h0000;
    end else if (w_load_acc) begin
      r_mem[mem_bus.load_addr] <= mem_bus.load_data;
    end else if (w_core_wr) begin
      r_mem[mem_bus.ram_addr] <= mem_bus.data_out;
    end
  end

  // Zero on the reload edge so the first LOAD cycle already shows 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_in <= 16'h0000;
    end else if (!w_loading && !mem_bus.reload) begin
      r_data_in <= r_mem[mem_bus.ram_addr];
    end else begin
      r_data_in <= 16'h0000;
    end
  end

  assign mem_bus.data_in    = r_data_in;
  assign mem_bus.load_ready = w_loading;
  assign mem_bus.core_hold  = w_loading;
endmodule
